// File: rtl/adc_spi_reader.sv
// SPI master that scans an ADC128S022-class 12-bit ADC over channels 0..NUM_CH-1.
// Optional macro ADC_CH_TABLE_EN adds a per-channel holding bank with a rd_sel/rd_data read port.
module adc_spi_reader #(
  parameter int CLK_DIV = 8,
  parameter int NUM_CH  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  input  logic        adc_dout,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        sample_valid,
  output logic        busy
`ifdef ADC_CH_TABLE_EN
  ,
  input  logic [2:0]  rd_sel,
  output logic [11:0] rd_data
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SETUP = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;
  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [2:0] CH_LAST  = 3'(NUM_CH - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [4:0]  half_q, half_d;
  logic [7:0]  gap_q, gap_d;
  logic        prime_q, prime_d;
  logic        frame_prime_q, frame_prime_d;
  logic [2:0]  addr_q, addr_d;
  logic [2:0]  tag_q, tag_d;
  logic [11:0] shreg_q, shreg_d;
  logic        cs_n_q, cs_n_d;
  logic        sclk_q, sclk_d;
  logic        din_q, din_d;
  logic        busy_q, busy_d;
  logic [11:0] data_q, data_d;
  logic [2:0]  ch_q, ch_d;
  logic        valid_q, valid_d;
  logic        div_last_s;

  function automatic logic [2:0] next_addr(input logic [2:0] a);
    if (a == CH_LAST) begin
      return 3'd0;
    end else begin
      return a + 3'd1;
    end
  endfunction

  function automatic logic tx_bit(input logic [2:0] a, input logic [3:0] idx);
    logic [15:0] w;
    w = {2'b00, a, 11'd0};
    return w[4'd15 - idx];
  endfunction

  assign div_last_s = (div_q == DIV_LAST);

  // Next-state logic; the shift register keeps only the low 12 bits, so the leading zeros fall off.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    half_d        = half_q;
    gap_d         = gap_q;
    prime_d       = prime_q;
    frame_prime_d = frame_prime_q;
    addr_d        = addr_q;
    tag_d         = tag_q;
    shreg_d       = shreg_q;
    din_d         = din_q;
    data_d        = data_q;
    ch_d          = ch_q;
    valid_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          prime_d = 1'b1;
        end else begin
          prime_d = prime_q;
        end
        if (gap_q != DIV_LAST) begin
          gap_d = gap_q + 8'd1;
        end else begin
          gap_d = gap_q;
        end
        if (enable && (gap_q == DIV_LAST)) begin
          state_d       = ST_SETUP;
          div_d         = 8'd0;
          frame_prime_d = prime_q;
          prime_d       = 1'b0;
          tag_d         = addr_q;
          addr_d        = prime_q ? 3'd0 : next_addr(addr_q);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (div_last_s) begin
          state_d = ST_SHIFT;
          div_d   = 8'd0;
          half_d  = 5'd0;
          din_d   = tx_bit(addr_q, 4'd0);
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_SHIFT: begin
        if (div_last_s) begin
          div_d = 8'd0;
          if (half_q[0]) begin
            shreg_d = {shreg_q[10:0], adc_dout};
          end else begin
            shreg_d = shreg_q;
          end
          if (half_q == 5'd31) begin
            state_d = ST_HOLD;
            din_d   = 1'b0;
          end else begin
            half_d = half_q + 5'd1;
            if (half_q[0]) begin
              din_d = tx_bit(addr_q, half_q[4:1] + 4'd1);
            end else begin
              din_d = din_q;
            end
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (div_last_s) begin
          state_d = ST_IDLE;
          gap_d   = 8'd0;
          if (!frame_prime_q) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
            ch_d    = tag_q;
          end else begin
            valid_d = 1'b0;
          end
        end else begin
          div_d = div_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cs_n_d = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    sclk_d = !((state_d == ST_SHIFT) && !half_d[0]);
  end

  // State and output registers; pins are registered from next-state so they line up with the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      div_q         <= 8'd0;
      half_q        <= 5'd0;
      gap_q         <= DIV_LAST;
      prime_q       <= 1'b1;
      frame_prime_q <= 1'b1;
      addr_q        <= 3'd0;
      tag_q         <= 3'd0;
      shreg_q       <= 12'd0;
      cs_n_q        <= 1'b1;
      sclk_q        <= 1'b1;
      din_q         <= 1'b0;
      busy_q        <= 1'b0;
      data_q        <= 12'd0;
      ch_q          <= 3'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      half_q        <= half_d;
      gap_q         <= gap_d;
      prime_q       <= prime_d;
      frame_prime_q <= frame_prime_d;
      addr_q        <= addr_d;
      tag_q         <= tag_d;
      shreg_q       <= shreg_d;
      cs_n_q        <= cs_n_d;
      sclk_q        <= sclk_d;
      din_q         <= din_d;
      busy_q        <= busy_d;
      data_q        <= data_d;
      ch_q          <= ch_d;
      valid_q       <= valid_d;
    end
  end

  assign adc_cs_n     = cs_n_q;
  assign adc_sclk     = sclk_q;
  assign adc_din      = din_q;
  assign busy         = busy_q;
  assign sample_data  = data_q;
  assign sample_ch    = ch_q;
  assign sample_valid = valid_q;

`ifdef ADC_CH_TABLE_EN
  logic [11:0] bank_q [0:7];

  // Per-channel holding bank, written together with the sample output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        bank_q[i] <= 12'd0;
      end
    end else if (valid_d) begin
      bank_q[ch_d] <= data_d;
    end else begin
      bank_q[ch_d] <= bank_q[ch_d];
    end
  end

  assign rd_data = ({1'b0, rd_sel} < 4'(NUM_CH)) ? bank_q[rd_sel] : 12'd0;
`endif

endmodule
